mips_if_stage: RTL
==================

MIPS_IF_STAGE -- requirements
Module: mips_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 Parameter IMEM_AW, default 8, word-address width of the instruction memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears immediately while reset=0.
REQ-005 imem_addr  output  IMEM_AW  word index into instruction memory, equal to pc[IMEM_AW+1:2].
REQ-006 imem_rdata  input  32  instruction word; combinational read of imem_addr in the same cycle.
REQ-007 stall  input  1  hazard unit hold request; freezes PC and IF/ID.
REQ-008 redirect  input  1  taken branch or jump resolved downstream this cycle.
REQ-009 redirect_pc  input  32  byte target address for redirect.
REQ-010 pc  output  32  current fetch PC.
REQ-011 if_id_instr  output  32  registered instruction for decode.
REQ-012 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 fetch_cnt  output  32  count of instructions accepted into IF/ID.
REQ-015 stall_cnt  output  32  count of cycles with stall=1 and redirect=0.

Function
REQ-016 Each edge exactly one action SHALL occur, priority: redirect > stall > advance.
REQ-017 Advance: pc <= pc+4; if_id_instr <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_cnt increments.
REQ-018 Stall: pc, if_id_instr, if_id_pc4, if_id_valid SHALL hold; stall_cnt increments; fetch_cnt holds.
REQ-019 Redirect: pc <= redirect_pc; if_id_instr <= 32'h0000_0000; if_id_pc4 <= 0; if_id_valid <= 0 (wrong-path flush), regardless of stall.
REQ-020 Redirect with stall=1 SHALL behave exactly as redirect alone; stall_cnt SHALL NOT increment.
REQ-021 PC arithmetic SHALL be modulo 2^32; pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-023 imem_addr SHALL wrap naturally by truncation; no range error is flagged.
REQ-024 fetch_cnt and stall_cnt SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-025 Fetch-to-decode latency SHALL be one cycle: instruction at pc in cycle N appears on if_id_instr after edge N.
REQ-026 A redirect SHALL cost exactly one bubble: the instruction at redirect_pc is in IF/ID one edge after the redirect edge.
REQ-027 No combinational path SHALL exist from stall or redirect to imem_addr; imem_addr depends only on pc.

Reset
REQ-028 While reset=0: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_cnt=0, stall_cnt=0.
REQ-029 Reset asserted mid-operation (including during stall or redirect) SHALL clear all state asynchronously, without waiting for a clock edge.
REQ-030 First edge after reset deasserts SHALL perform a normal advance from RESET_PC.

Verification
REQ-031 Sequential fetch: mem[0..3]=32'h20080001..04, no stall/redirect, 4 edges -> if_id_instr sequence 20080001..20080004, if_id_pc4 4,8,12,16, pc=16, fetch_cnt=4.
REQ-032 Stall: after 2 advances assert stall for 3 edges -> pc stays 8, if_id_instr stays mem[1], stall_cnt=3, fetch_cnt=2; release -> mem[2] next edge.
REQ-033 Redirect: at pc=12 pulse redirect with redirect_pc=32'h40 -> next edge pc=0x40, if_id_valid=0, if_id_instr=0; following edge if_id_instr=mem[16], if_id_pc4=0x44.
REQ-034 Simultaneous: stall=1 and redirect=1, redirect_pc=32'h23 -> pc=0x20, bubble in IF/ID, stall_cnt unchanged.
REQ-035 Wrap/saturation: force pc=32'hFFFF_FFFC, advance -> pc=0; preload stall_cnt=32'hFFFF_FFFF, stall one edge -> stays 32'hFFFF_FFFF.
REQ-036 Async reset: drop reset between edges at pc=0x40 -> all outputs reach reset values before next edge; release -> first edge fetches mem[0].

Source files
------------

// File: rtl/mips_if_stage.sv
// mips_if_stage: MIPS instruction-fetch stage with PC register, IF/ID pipeline register and fetch/stall counters
//   clk, reset (async active-low)        : clock and reset
//   imem_addr / imem_rdata               : word index out, combinational instruction word in
//   stall, redirect, redirect_pc         : hold request, taken-branch flush and its byte target
//   pc, if_id_instr, if_id_pc4, if_id_valid : fetch PC and IF/ID register contents
//   fetch_cnt, stall_cnt                 : saturating event counters
module mips_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
);
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] w_pc4;
    assign w_pc4     = r_pc + 32'd4;
    assign imem_addr = r_pc[IMEM_AW+1:2];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_pc4       <= '0;
            r_valid     <= 1'b0;
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_stall_cnt <= (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 32'd1;
        end else begin
            r_pc        <= w_pc4;
            r_instr     <= imem_rdata;
            r_pc4       <= w_pc4;
            r_valid     <= 1'b1;
            r_fetch_cnt <= (&r_fetch_cnt) ? r_fetch_cnt : r_fetch_cnt + 32'd1;
        end
    end
    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign fetch_cnt   = r_fetch_cnt;
    assign stall_cnt   = r_stall_cnt;
endmodule
